// File: rtl/float_sort3_serial.sv
// Serial three-value float sorter: collect three words, bubble-sort them in place
// through one shared comparator, then stream them out in increasing order.

// IEEE-754 a <= b. Unordered operands (any NaN) raise err and report res=0.
module f_less_or_equal #(
   parameter int unsigned FLEN = 64
) (
   input  logic [FLEN-1:0] a,
   input  logic [FLEN-1:0] b,
   output logic            res,
   output logic            err
);
   localparam int unsigned EW = (FLEN == 16) ? 5 : (FLEN == 32) ? 8 : (FLEN == 128) ? 15 : 11;
   localparam int unsigned MW = FLEN - 1 - EW;

   logic            a_nan, b_nan, a_s, b_s;
   logic [FLEN-2:0] a_mag, b_mag;

   always_comb begin
      a_s   = a[FLEN-1];
      b_s   = b[FLEN-1];
      a_mag = a[FLEN-2:0];
      b_mag = b[FLEN-2:0];
      a_nan = (&a[FLEN-2 -: EW]) & (|a[MW-1:0]);
      b_nan = (&b[FLEN-2 -: EW]) & (|b[MW-1:0]);
      err   = a_nan | b_nan;
      res   = 1'b0;
      if (err) begin
         res = 1'b0;
      end else if ((a_mag == '0) && (b_mag == '0)) begin
         res = 1'b1;                      // +0 and -0 compare equal
      end else if (a_s != b_s) begin
         res = a_s;
      end else if (!a_s) begin
         res = (a_mag <= b_mag);
      end else begin
         res = (a_mag >= b_mag);
      end
   end
endmodule

module float_sort3_serial #(
   parameter int unsigned FLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            up_valid,
   output logic            up_ready,
   input  logic [FLEN-1:0] up_data,
   output logic            down_valid,
   input  logic            down_ready,
   output logic [FLEN-1:0] down_data,
   output logic            down_err
);
   localparam int unsigned IW = 2;

   typedef enum logic [2:0] {
      COLLECT = 3'd0,
      CMP01A  = 3'd1,
      CMP12   = 3'd2,
      CMP01B  = 3'd3,
      EMIT    = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            grp_err_q, grp_err_d;
   logic [FLEN-1:0] buf_q [3];
   logic [FLEN-1:0] buf_d [3];

   logic [FLEN-1:0] cmp_a, cmp_b;
   logic            cmp_res, cmp_err;

   // Operand select for the single shared comparator
   always_comb begin
      cmp_a = buf_q[0];
      cmp_b = buf_q[1];
      if (state_q == CMP12) begin
         cmp_a = buf_q[1];
         cmp_b = buf_q[2];
      end
   end

   f_less_or_equal #(.FLEN(FLEN)) u_cmp (
      .a   (cmp_a),
      .b   (cmp_b),
      .res (cmp_res),
      .err (cmp_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= COLLECT;
         idx_q     <= '0;
         grp_err_q <= 1'b0;
         for (int i = 0; i < 3; i++) buf_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         grp_err_q <= grp_err_d;
         for (int i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
      end
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      grp_err_d  = grp_err_q;
      for (int i = 0; i < 3; i++) buf_d[i] = buf_q[i];
      up_ready   = 1'b0;
      down_valid = 1'b0;
      down_err   = 1'b0;
      down_data  = buf_q[idx_q];

      case (state_q)
         COLLECT: begin
            up_ready = 1'b1;
            if (up_valid) begin
               buf_d[idx_q] = up_data;
               if (idx_q == IW'(2)) begin
                  idx_d     = '0;
                  grp_err_d = 1'b0;
                  state_d   = CMP01A;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         CMP01A, CMP01B: begin
            grp_err_d = grp_err_q | cmp_err;
            if (!cmp_res) begin
               buf_d[0] = buf_q[1];
               buf_d[1] = buf_q[0];
            end
            state_d = (state_q == CMP01A) ? CMP12 : EMIT;
         end
         CMP12: begin
            grp_err_d = grp_err_q | cmp_err;
            if (!cmp_res) begin
               buf_d[1] = buf_q[2];
               buf_d[2] = buf_q[1];
            end
            state_d = CMP01B;
         end
         EMIT: begin
            down_valid = 1'b1;
            down_err   = grp_err_q;
            if (down_ready) begin
               if (idx_q == IW'(2)) begin
                  idx_d   = '0;
                  state_d = COLLECT;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: begin
            state_d = COLLECT;
            idx_d   = '0;
         end
      endcase
   end
endmodule

// File: doc/float_sort3_serial.md
# float_sort3_serial

Sequential three-value floating-point sorter on a serial valid/ready stream. It collects three FLEN-bit floats one per handshake and orders them in place with a three-pass bubble network built on a single shared `f_less_or_equal` instance. It then emits the three values in increasing order, one per handshake. It is the streaming, area-reduced counterpart of the combinational three-float sorter, for datapaths that deliver operands serially and tolerate multi-cycle latency.

## Interface
- `FLEN`: from the shared cvw config header, normally 64 (FP64). Not overridden locally.
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous reset, active-high
- `up_valid`  in  1  input word valid
- `up_ready`  out  1  block can accept an input word
- `up_data`  in  FLEN  input float
- `down_valid`  out  1  output word valid
- `down_ready`  in  1  consumer accepts the output word
- `down_data`  out  FLEN  sorted output float
- `down_err`  out  1  set with every output word of a group in which any comparison reported err

## Operation
- Storage: three FLEN-bit registers `buf[0..2]`, a 2-bit index `idx` and a sticky `grp_err` flag.
- Exactly one `f_less_or_equal` instance (`a=buf[i]`, `b=buf[i+1]`). Its operand select is driven by state.
- States:
  - COLLECT (reset state): `up_ready=1`. On `up_valid&up_ready`, `buf[idx]<=up_data`, `idx++`. On the third accept, `idx<=0`, `grp_err<=0`, go to CMP01A.
  - CMP01A: compare `buf[0]`,`buf[1]`. Go to CMP12.
  - CMP12: compare `buf[1]`,`buf[2]`. Go to CMP01B.
  - CMP01B: compare `buf[0]`,`buf[1]`. Go to EMIT.
  - EMIT: `down_valid=1`, `down_data=buf[idx]`, `down_err=grp_err`. On `down_valid&down_ready`, `idx++`. On the third transfer, `idx<=0` and go to COLLECT.
- In each CMP state, the pair is swapped iff `res==0`. Equal values are never swapped, so the sort is stable.
- Each comparison ORs its `err` into `grp_err`. On err the swap still follows `res` exactly as the comparator reports it, and the group is still emitted in full.
- `up_ready=0` in every state except COLLECT. Input presented then is not accepted and must be held by the sender.
- `up_ready`, `down_valid` and `down_err` are decoded from registered state. No combinational path from `up_valid` or `down_ready` to any output.
- `down_data` is a mux of `buf` by `idx`. Outside EMIT its value is don't-care for the protocol.

## Timing
- Reset: `rst=1` at an edge gives state COLLECT, `idx=0`, `grp_err=0` and all `buf=0`. Outputs: `up_ready=1`, `down_valid=0`, `down_err=0`, `down_data=0`.
- Reset mid-operation (any state) aborts the group. Partially collected or unsent words are discarded.
- Latency: third input accepted at edge T gives CMP01A at T..T+1, CMP12 at T+1..T+2 and CMP01B at T+2..T+3. `down_valid=1` from the cycle after edge T+3.
- With `down_ready` held high, the three outputs transfer on consecutive edges T+4, T+5 and T+6. `up_ready` returns high after edge T+6.
- Throughput with no stalls: 3 in + 3 compare + 3 out = 9 cycles per group. Groups do not overlap.
- Backpressure: while `down_ready=0`, `down_valid`, `down_data` and `down_err` hold stable and `idx` does not advance.
- Gaps in `up_valid` simply extend COLLECT. `idx` holds.

## Test plan
- Reverse order: in 3.0 (`4008000000000000`), 2.0 (`4000000000000000`), 1.0 (`3FF0000000000000`), `down_ready=1` -> out 1.0, 2.0, 3.0. `down_err=0`. First `down_valid` 4 cycles after the third accept.
- Mixed signs: in 2.0, -1.0 (`BFF0000000000000`), 1.0 -> out -1.0, 1.0, 2.0. Then a second group 1.0, 3.0, 2.0 immediately -> 1.0, 2.0, 3.0. `up_ready=0` throughout compare/emit.
- Backpressure: sorted group 1.0, 2.0, 3.0, with `down_ready` toggling 0,0,1,0,1,1 -> `down_data` holds across stalls. Exactly three transfers in order 1.0, 2.0, 3.0.
- NaN: in 1.0, NaN (`7FF8000000000000`), 2.0 -> three outputs, each with `down_err=1`. The next clean group has `down_err=0`.
- Reset mid-operation: assert `rst` for one cycle during CMP12 (and separately during the second EMIT word) -> `down_valid=0`, `up_ready=1` next cycle. A following group 3.0, 1.0, 2.0 emits 1.0, 2.0, 3.0.
- Equal keys / input gaps: `up_valid` with idle cycles between 2.0, 2.0, 1.0 -> out 1.0, 2.0, 2.0. The two 2.0 words keep their arrival order (check with distinguishable +0 `0000…`/-0 `8000…` pair: -0, +0 in -> -0, +0 out).
